// File: rtl/risc_pkg.sv
// Shared CPU types for the register file and its read-port muxes.
// Architectural defaults; modules size their own ports from parameters.
package risc_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int REG_ZERO  = 0;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [REG_IDX_W-1:0] regidx_t;
endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: hardwired-zero register, write-first bypass, else array data.
module regfile_bypass_mux
  import risc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = arr_data;
    if (rd_idx == IDX_W'(REG_ZERO)) begin
      rd_data = '0;
    end else if (wb_en && (wb_idx == rd_idx)) begin
      rd_data = wb_data;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-first bypass and a per-register busy
// scoreboard (set on issue, cleared on writeback or flush).
module regfile_scoreboard
  import risc_pkg::*;
#(
  parameter  int DATA_W   = $bits(word_t),
  parameter  int NUM_REGS = 2 ** $bits(regidx_t),
  parameter  int NUM_RD   = 2,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_hazard,
  input  logic                     wb_en,
  input  logic [IDX_W-1:0]         wb_idx,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     issue_en,
  input  logic [IDX_W-1:0]         issue_idx,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_idx != IDX_W'(REG_ZERO))) begin
      regs_d[wb_idx] = wb_data;
    end
  end

  // Issue is applied after writeback so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_en) begin
        busy_d[wb_idx] = 1'b0;
      end
      if (issue_en) begin
        busy_d[issue_idx] = 1'b1;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [IDX_W-1:0] idx;
    assign idx = rd_idx[gi*IDX_W +: IDX_W];

    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_mux (
      .rd_idx   (idx),
      .arr_data (regs_q[idx]),
      .wb_en    (wb_en),
      .wb_idx   (wb_idx),
      .wb_data  (wb_data),
      .rd_data  (rd_data[gi*DATA_W +: DATA_W])
    );

    // A same-cycle writeback is forwarded, so it never stalls the reader.
    assign rd_hazard[gi] = busy_q[idx] & ~(wb_en && (wb_idx == idx));
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of the register file scoreboard: default build plus a
// 64-bit / 16-register / 3-port build.
module tb_regfile_scoreboard;

  logic        clk;
  logic        nRST;

  // default build: DATA_W=32, NUM_REGS=32, NUM_RD=2
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  rd_hazard;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        issue_en;
  logic [4:0]  issue_idx;
  logic        flush;
  logic [31:0] busy_vec;

  // swept build: DATA_W=64, NUM_REGS=16, NUM_RD=3
  logic [11:0]  s_rd_idx;
  logic [191:0] s_rd_data;
  logic [2:0]   s_rd_hazard;
  logic         s_wb_en;
  logic [3:0]   s_wb_idx;
  logic [63:0]  s_wb_data;
  logic         s_issue_en;
  logic [3:0]   s_issue_idx;
  logic         s_flush;
  logic [15:0]  s_busy_vec;

  int n_vec;
  int n_err;

  regfile_scoreboard dut (
    .clk       (clk),
    .nRST      (nRST),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_hazard (rd_hazard),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .issue_en  (issue_en),
    .issue_idx (issue_idx),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  regfile_scoreboard #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(3)) dut_s (
    .clk       (clk),
    .nRST      (nRST),
    .rd_idx    (s_rd_idx),
    .rd_data   (s_rd_data),
    .rd_hazard (s_rd_hazard),
    .wb_en     (s_wb_en),
    .wb_idx    (s_wb_idx),
    .wb_data   (s_wb_data),
    .issue_en  (s_issue_en),
    .issue_idx (s_issue_idx),
    .flush     (s_flush),
    .busy_vec  (s_busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; wb_idx = '0; wb_data = '0;
    issue_en = 1'b0; issue_idx = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    s_rd_idx = '0; s_wb_en = 1'b0; s_wb_idx = '0; s_wb_data = '0;
    s_issue_en = 1'b0; s_issue_idx = '0; s_flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rd_idx    = 10'($urandom);
      wb_en     = 1'($urandom);
      wb_idx    = 5'($urandom_range(1, 31));
      wb_data   = $urandom;
      issue_en  = 1'($urandom);
      issue_idx = 5'($urandom_range(1, 31));
      flush     = 1'($urandom);
      tick();
      n_vec++;
      if (busy_vec !== 32'h0) begin
        $display("FAIL reset_busy_held: got %h want %h", busy_vec, 32'h0);
        n_err++;
      end
    end
    idle();
    nRST = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      rd_idx = {5'(31 - i), 5'(i)};
      #1;
      n_vec++;
      if (rd_data !== 64'h0 || rd_hazard !== 2'b00) begin
        $display("FAIL reset_read r%0d: data %h hazard %b want 0 00", i, rd_data, rd_hazard);
        n_err++;
      end
    end
    n_vec++;
    if (busy_vec !== 32'h0) begin
      $display("FAIL reset_busy: got %h want %h", busy_vec, 32'h0);
      n_err++;
    end
  endtask

  task automatic test_zero_write();
    wb_en = 1'b1; wb_idx = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    idle();
    rd_idx = {5'd0, 5'd5};
    #1;
    n_vec++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL r5_init: got %h want %h", rd_data[31:0], 32'hDEADBEEF);
      n_err++;
    end
    wb_en = 1'b1; wb_idx = 5'd5; wb_data = 32'h0;
    tick();
    idle();
    #1;
    n_vec++;
    if (rd_data[31:0] !== 32'h0) begin
      $display("FAIL r5_zero_write: got %h want %h", rd_data[31:0], 32'h0);
      n_err++;
    end
    // write to r0 while reading r0: neither bypass nor storage may leak
    wb_en = 1'b1; wb_idx = 5'd0; wb_data = 32'h1234;
    issue_en = 1'b1; issue_idx = 5'd0;
    rd_idx = {5'd0, 5'd0};
    #1;
    n_vec++;
    if (rd_data !== 64'h0 || rd_hazard !== 2'b00) begin
      $display("FAIL r0_bypass: data %h hazard %b want 0 00", rd_data, rd_hazard);
      n_err++;
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (rd_data !== 64'h0 || busy_vec !== 32'h0) begin
      $display("FAIL r0_after_write: data %h busy %h want 0 0", rd_data, busy_vec);
      n_err++;
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_idx = 5'd7; wb_data = 32'hA5A5A5A5;
    rd_idx = {5'd7, 5'd7};
    #1;
    n_vec++;
    if (rd_data !== 64'hA5A5A5A5_A5A5A5A5) begin
      $display("FAIL bypass_same_cycle: got %h want %h", rd_data, 64'hA5A5A5A5_A5A5A5A5);
      n_err++;
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (rd_data !== 64'hA5A5A5A5_A5A5A5A5) begin
      $display("FAIL bypass_stored: got %h want %h", rd_data, 64'hA5A5A5A5_A5A5A5A5);
      n_err++;
    end
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1; issue_idx = 5'd9;
    tick();
    idle();
    rd_idx = {5'd7, 5'd9};
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_vec++;
      if (rd_hazard !== 2'b01 || busy_vec !== 32'h0000_0200) begin
        $display("FAIL sb_pending c%0d: hazard %b busy %h want 01 00000200", c, rd_hazard, busy_vec);
        n_err++;
      end
      tick();
    end
    wb_en = 1'b1; wb_idx = 5'd9; wb_data = 32'h42;
    #1;
    n_vec++;
    if (rd_hazard !== 2'b00 || rd_data[31:0] !== 32'h42) begin
      $display("FAIL sb_wb_cycle: hazard %b data %h want 00 00000042", rd_hazard, rd_data[31:0]);
      n_err++;
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (busy_vec !== 32'h0 || rd_hazard !== 2'b00 || rd_data[31:0] !== 32'h42) begin
      $display("FAIL sb_retired: busy %h hazard %b data %h want 0 00 42", busy_vec, rd_hazard, rd_data[31:0]);
      n_err++;
    end
    // writeback to a register that is not busy keeps it not busy
    wb_en = 1'b1; wb_idx = 5'd11; wb_data = 32'h1111_2222;
    tick();
    idle();
    rd_idx = {5'd0, 5'd11};
    #1;
    n_vec++;
    if (busy_vec !== 32'h0 || rd_data[31:0] !== 32'h1111_2222) begin
      $display("FAIL wb_not_busy: busy %h data %h want 0 11112222", busy_vec, rd_data[31:0]);
      n_err++;
    end
  endtask

  task automatic test_issue_wb_flush();
    issue_en = 1'b1; issue_idx = 5'd10;
    tick();
    issue_en = 1'b1; issue_idx = 5'd3;
    wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'h33;
    tick();
    idle();
    rd_idx = {5'd3, 5'd10};
    #1;
    n_vec++;
    if (busy_vec !== 32'h0000_0408 || rd_hazard !== 2'b11) begin
      $display("FAIL issue_over_wb: busy %h hazard %b want 00000408 11", busy_vec, rd_hazard);
      n_err++;
    end
    flush = 1'b1;
    issue_en = 1'b1; issue_idx = 5'd4;
    wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'h77;
    #1;
    n_vec++;
    if (rd_hazard !== 2'b01 || rd_data !== {32'h77, 32'h0}) begin
      $display("FAIL flush_cycle: hazard %b data %h want 01 0000007700000000", rd_hazard, rd_data);
      n_err++;
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (busy_vec !== 32'h0 || rd_hazard !== 2'b00 || rd_data[63:32] !== 32'h77) begin
      $display("FAIL flush_after: busy %h hazard %b r3 %h want 0 00 77", busy_vec, rd_hazard, rd_data[63:32]);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      wb_en = 1'b1; wb_idx = 5'(20 + i); wb_data = 32'(i * 32'h0101_0101);
      rd_idx = {5'(20 + i), 5'(19 + i)};
      #1;
      n_vec++;
      if (rd_data[63:32] !== 32'(i * 32'h0101_0101) ||
          (i > 1 && rd_data[31:0] !== 32'((i - 1) * 32'h0101_0101))) begin
        $display("FAIL b2b_write%0d: got %h", i, rd_data);
        n_err++;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    wb_en = 1'b1; wb_idx = 5'd12; wb_data = 32'h1111;
    tick();
    idle();
    issue_en = 1'b1; issue_idx = 5'd12;
    tick();
    idle();
    rd_idx = {5'd0, 5'd12};
    #1;
    n_vec++;
    if (busy_vec !== 32'h0000_1000 || rd_data[31:0] !== 32'h1111) begin
      $display("FAIL pre_reset: busy %h data %h want 00001000 1111", busy_vec, rd_data[31:0]);
      n_err++;
    end
    nRST = 1'b0;
    #1;
    n_vec++;
    if (busy_vec !== 32'h0 || rd_data !== 64'h0 || rd_hazard !== 2'b00) begin
      $display("FAIL async_reset: busy %h data %h hazard %b want 0 0 00", busy_vec, rd_data, rd_hazard);
      n_err++;
    end
    tick();
    nRST = 1'b1;
    wb_en = 1'b1; wb_idx = 5'd12; wb_data = 32'hCAFE;
    issue_en = 1'b1; issue_idx = 5'd2;
    tick();
    idle();
    #1;
    n_vec++;
    if (rd_data[31:0] !== 32'hCAFE || busy_vec !== 32'h0000_0004) begin
      $display("FAIL post_reset_edge: data %h busy %h want cafe 00000004", rd_data[31:0], busy_vec);
      n_err++;
    end
  endtask

  task automatic test_param_sweep();
    s_wb_en = 1'b1; s_wb_idx = 4'd7; s_wb_data = 64'h0123_4567_89AB_CDEF;
    s_rd_idx = {4'd7, 4'd7, 4'd7};
    #1;
    for (int p = 0; p < 3; p++) begin
      n_vec++;
      if (s_rd_data[p*64 +: 64] !== 64'h0123_4567_89AB_CDEF) begin
        $display("FAIL sweep_bypass p%0d: got %h want 0123456789abcdef", p, s_rd_data[p*64 +: 64]);
        n_err++;
      end
    end
    tick();
    s_wb_en = 1'b0;
    #1;
    n_vec++;
    if (s_rd_data !== {3{64'h0123_4567_89AB_CDEF}}) begin
      $display("FAIL sweep_stored: got %h", s_rd_data);
      n_err++;
    end
    s_issue_en = 1'b1; s_issue_idx = 4'd9;
    tick();
    s_issue_idx = 4'd15;
    tick();
    s_issue_en = 1'b0;
    s_rd_idx = {4'd0, 4'd15, 4'd9};
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_vec++;
      if (s_rd_hazard !== 3'b011 || s_busy_vec !== 16'h8200) begin
        $display("FAIL sweep_pending c%0d: hazard %b busy %h want 011 8200", c, s_rd_hazard, s_busy_vec);
        n_err++;
      end
      tick();
    end
    s_wb_en = 1'b1; s_wb_idx = 4'd9; s_wb_data = 64'h42;
    #1;
    n_vec++;
    if (s_rd_hazard !== 3'b010 || s_rd_data[63:0] !== 64'h42) begin
      $display("FAIL sweep_wb_cycle: hazard %b data %h want 010 42", s_rd_hazard, s_rd_data[63:0]);
      n_err++;
    end
    tick();
    s_wb_en = 1'b0;
    #1;
    n_vec++;
    if (s_busy_vec !== 16'h8000 || s_rd_hazard !== 3'b010) begin
      $display("FAIL sweep_retired: busy %h hazard %b want 8000 010", s_busy_vec, s_rd_hazard);
      n_err++;
    end
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    #1;
    n_vec++;
    if (s_busy_vec !== 16'h0 || s_rd_hazard !== 3'b000) begin
      $display("FAIL sweep_flush: busy %h hazard %b want 0 000", s_busy_vec, s_rd_hazard);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rd_idx = '0;
    test_reset();
    test_zero_write();
    test_bypass();
    test_scoreboard();
    test_issue_wb_flush();
    test_back_to_back();
    test_async_reset();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-issue CPU register file.
- Adds N configurable read ports, write-first bypass, a per-register busy scoreboard (set on issue, cleared on writeback) and a flush.
- Sits between decode/issue (index lookup, hazard check) and writeback in the pipelined core.
- Hazard outputs drive the issue-stage stall logic.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, architectural register count; must be a power of 2, minimum 2.
- NUM_RD, 2, number of read ports.
- IDX_W, $clog2(NUM_REGS), index width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- rd_idx  in  NUM_RD*IDX_W  packed read indices; port i occupies bits [i*IDX_W +: IDX_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_hazard  out  NUM_RD  per-port "operand not yet produced" flag.
- wb_en  in  1  writeback strobe.
- wb_idx  in  IDX_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- issue_en  in  1  instruction issued with a destination register.
- issue_idx  in  IDX_W  destination of the issued instruction.
- flush  in  1  synchronous clear of all busy bits; register data is untouched.
- busy_vec  out  NUM_REGS  current scoreboard, for debug and perf counters.

Behaviour:
- Reset (nRST low, asynchronous): all registers = 0, all busy bits = 0. Consequently rd_data = 0, rd_hazard = 0, busy_vec = 0.
- Register 0 is hardwired to zero:
  - Writes to index 0 are discarded.
  - issue_idx = 0 never sets busy.
  - Reads of index 0 return 0 and rd_hazard = 0, even when wb_idx = 0 is written in the same cycle.
- Write: on the rising clk edge with wb_en = 1 and wb_idx != 0, reg[wb_idx] <= wb_data.
  - Writing a data value of 0 is a normal write. No data-dependent gating.
- Read latency is 0 cycles (combinational).
- Write-first bypass: if wb_en = 1 and wb_idx = rd_idx[i] != 0, then rd_data[i] = wb_data in the same cycle. Otherwise rd_data[i] = reg[rd_idx[i]].
- Scoreboard next-state, per register r != 0, evaluated in this priority order:
  - flush = 1: busy[r] <= 0. Overrides issue and writeback in that cycle.
  - issue_en = 1 and issue_idx = r: busy[r] <= 1. Overrides a same-cycle writeback to r, because a new producer supersedes the retiring one.
  - wb_en = 1 and wb_idx = r: busy[r] <= 0.
  - Otherwise busy[r] holds.
- Hazard: rd_hazard[i] = busy[rd_idx[i]] AND NOT (wb_en AND wb_idx = rd_idx[i]).
  - The same-cycle writeback is forwarded, so no stall is raised.
  - flush does not mask the current-cycle hazard; it takes effect next cycle.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Multiple in-flight producers of the same register are not tracked; the first writeback clears busy. The issue stage is responsible for preventing WAW.
- Reset asserted mid-operation clears data and scoreboard immediately. The first post-reset edge behaves as a normal cycle.

Decomposition:
- Shared package (cpu package, risc_pkg): word_t (DATA_W), regidx_t (IDX_W), REG_ZERO = 0.
- Sub-module regfile_bypass_mux: one instance per read port; implements the zero/bypass/array select. The top level generates NUM_RD copies.
- Scoreboard and array stay in the top module.

Test Plan:
- Reset check: hold nRST low with random inputs, then release. All 32 registers read 0, busy_vec = 0, rd_hazard = 0.
- Zero write: write 0x0 to r5 after r5 = 0xDEADBEEF. rd_idx0 = 5 reads 0x00000000 next cycle (the zero-data write is honoured). A write of 0x1234 to r0 still reads 0.
- Bypass: wb_en = 1, wb_idx = 7, wb_data = 0xA5A5A5A5, rd_idx0 = rd_idx1 = 7 in the same cycle. Both ports read 0xA5A5A5A5 combinationally; reg[7] holds it on the next cycle.
- Scoreboard: issue r9 at cycle 0. Cycles 1-3 show rd_hazard = 1 on a port reading r9. At cycle 4, wb r9 = 0x42: the hazard drops in that cycle and data = 0x42. At cycle 5, busy[9] = 0.
- Simultaneous issue and writeback of r3 in one cycle: busy[3] = 1 afterwards. Same cycle with flush = 1: busy_vec = 0 afterwards.
- Parameter sweep with DATA_W = 64, NUM_REGS = 16, NUM_RD = 3: repeat the bypass and scoreboard tests. Randomised 10k cycles checked against a reference model with zero mismatches.
